// File: rtl/jpeg_mcu_buffer.sv
// Ping-pong 4:2:0 MCU buffer between IDCT and YCbCr->RGB; reads have 1-cycle registered latency.
// Writer backpressure via DataInIdle (write bank full); a bank frees when the converter moves ReadBank.
module jpeg_mcu_buffer #(
    parameter int BLOCK_W = 12,
    parameter int DATA_W  = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               DataInEnable,
    input  logic [2:0]         DataInBlock,
    input  logic [5:0]         DataInAddress,
    input  logic [DATA_W-1:0]  DataIn,
    input  logic [BLOCK_W-1:0] DataInBlockX,
    input  logic [BLOCK_W-1:0] DataInBlockY,
    output logic               DataInIdle,
    output logic               BlockEnable,
    output logic [BLOCK_W-1:0] BlockX,
    output logic [BLOCK_W-1:0] BlockY,
    input  logic               ReadIdle,
    input  logic               ReadBank,
    input  logic [7:0]         ReadAddress,
    output logic [DATA_W-1:0]  ReadY,
    output logic [DATA_W-1:0]  ReadCb,
    output logic [DATA_W-1:0]  ReadCr
);

    logic [DATA_W-1:0] y_mem  [0:511];
    logic [DATA_W-1:0] cb_mem [0:127];
    logic [DATA_W-1:0] cr_mem [0:127];

    logic [1:0]         full_q, full_d;
    logic               wr_bank_q, wr_bank_d;
    logic               started_q, started_d;
    logic               rb_prev_q;
    logic               block_enable_q, block_enable_d;
    logic [BLOCK_W-1:0] mcu_x_q [0:1];
    logic [BLOCK_W-1:0] mcu_y_q [0:1];
    logic [BLOCK_W-1:0] block_x_q, block_y_q;
    logic [DATA_W-1:0]  read_y_q, read_cb_q, read_cr_q;

    logic       wr_accept;
    logic       wr_done;
    logic       bank_release;
    logic [8:0] y_rd_idx;
    logic [6:0] c_rd_idx;

    assign DataInIdle   = ~full_q[wr_bank_q];
    assign wr_accept    = DataInEnable & DataInIdle & (DataInBlock <= 3'd5);
    assign wr_done      = wr_accept & (DataInBlock == 3'd5) & (DataInAddress == 6'd63);
    assign bank_release = (ReadBank != rb_prev_q);

    // Chroma is upsampled 2x2 simply by dropping the low bit of row and column.
    assign y_rd_idx = {ReadBank, ReadAddress[7], ReadAddress[3], ReadAddress[6:4], ReadAddress[2:0]};
    assign c_rd_idx = {ReadBank, ReadAddress[7:5], ReadAddress[3:1]};

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            if (!DataInBlock[2]) begin
                y_mem[{wr_bank_q, DataInBlock[1:0], DataInAddress}] <= DataIn;
            end else if (!DataInBlock[0]) begin
                cb_mem[{wr_bank_q, DataInAddress}] <= DataIn;
            end else begin
                cr_mem[{wr_bank_q, DataInAddress}] <= DataIn;
            end
        end
    end

    always_comb begin
        full_d         = full_q;
        wr_bank_d      = wr_bank_q;
        started_d      = started_q;
        block_enable_d = full_q[ReadBank] & ~started_q & ~bank_release;
        if (bank_release) begin
            full_d[rb_prev_q] = 1'b0;
            started_d         = 1'b0;
        end else if (block_enable_q && ReadIdle) begin
            started_d = 1'b1;
        end
        // Completing bank is never the one being released, so both updates stand.
        if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q         <= 2'b00;
            wr_bank_q      <= 1'b0;
            started_q      <= 1'b0;
            rb_prev_q      <= 1'b0;
            block_enable_q <= 1'b0;
            block_x_q      <= '0;
            block_y_q      <= '0;
            mcu_x_q[0]     <= '0;
            mcu_x_q[1]     <= '0;
            mcu_y_q[0]     <= '0;
            mcu_y_q[1]     <= '0;
            read_y_q       <= '0;
            read_cb_q      <= '0;
            read_cr_q      <= '0;
        end else begin
            full_q         <= full_d;
            wr_bank_q      <= wr_bank_d;
            started_q      <= started_d;
            rb_prev_q      <= ReadBank;
            block_enable_q <= block_enable_d;
            block_x_q      <= mcu_x_q[ReadBank];
            block_y_q      <= mcu_y_q[ReadBank];
            if (wr_accept) begin
                mcu_x_q[wr_bank_q] <= DataInBlockX;
                mcu_y_q[wr_bank_q] <= DataInBlockY;
            end
            read_y_q  <= y_mem[y_rd_idx];
            read_cb_q <= cb_mem[c_rd_idx];
            read_cr_q <= cr_mem[c_rd_idx];
        end
    end

    assign BlockEnable = block_enable_q;
    assign BlockX      = block_x_q;
    assign BlockY      = block_y_q;
    assign ReadY       = read_y_q;
    assign ReadCb      = read_cb_q;
    assign ReadCr      = read_cr_q;

endmodule

// File: tb/tb_jpeg_mcu_buffer.sv
// Directed bench for jpeg_mcu_buffer: fill/issue/read/release of both banks, dropped writes, async reset.
module tb_jpeg_mcu_buffer;

    localparam int BW = 12;
    localparam int DW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          DataInEnable;
    logic [2:0]    DataInBlock;
    logic [5:0]    DataInAddress;
    logic [DW-1:0] DataIn;
    logic [BW-1:0] DataInBlockX;
    logic [BW-1:0] DataInBlockY;
    logic          DataInIdle;
    logic          BlockEnable;
    logic [BW-1:0] BlockX;
    logic [BW-1:0] BlockY;
    logic          ReadIdle;
    logic          ReadBank;
    logic [7:0]    ReadAddress;
    logic [DW-1:0] ReadY;
    logic [DW-1:0] ReadCb;
    logic [DW-1:0] ReadCr;

    int checks   = 0;
    int failures = 0;

    jpeg_mcu_buffer #(.BLOCK_W(BW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .DataInEnable (DataInEnable),
        .DataInBlock  (DataInBlock),
        .DataInAddress(DataInAddress),
        .DataIn       (DataIn),
        .DataInBlockX (DataInBlockX),
        .DataInBlockY (DataInBlockY),
        .DataInIdle   (DataInIdle),
        .BlockEnable  (BlockEnable),
        .BlockX       (BlockX),
        .BlockY       (BlockY),
        .ReadIdle     (ReadIdle),
        .ReadBank     (ReadBank),
        .ReadAddress  (ReadAddress),
        .ReadY        (ReadY),
        .ReadCb       (ReadCb),
        .ReadCr       (ReadCr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int blk, input int addr, input int val);
        DataInEnable  = 1'b1;
        DataInBlock   = 3'(blk);
        DataInAddress = 6'(addr);
        DataIn        = DW'(val);
        tick();
        DataInEnable  = 1'b0;
    endtask

    // Y = n*64+addr (or its negated +1 form), Cb/Cr constant per MCU.
    task automatic write_mcu(input int bx, input int by, input int count, input bit neg);
        int n_done;
        int v;
        n_done = 0;
        DataInBlockX = BW'(bx);
        DataInBlockY = BW'(by);
        for (int b = 0; b < 6; b++) begin
            for (int a = 0; a < 64; a++) begin
                if (n_done < count) begin
                    if (b < 4)       v = neg ? -(b * 64 + a + 1) : (b * 64 + a);
                    else if (b == 4) v = neg ? 50 : 100;
                    else             v = neg ? -50 : -100;
                    wr(b, a, v);
                    n_done++;
                end
            end
        end
    endtask

    function automatic int sy(input logic [DW-1:0] d);
        return int'($signed(d));
    endfunction

    initial begin
        rst           = 1'b1;
        DataInEnable  = 1'b0;
        DataInBlock   = '0;
        DataInAddress = '0;
        DataIn        = '0;
        DataInBlockX  = '0;
        DataInBlockY  = '0;
        ReadIdle      = 1'b0;
        ReadBank      = 1'b0;
        ReadAddress   = '0;
        #2;
        chk("rst_idle",  int'(DataInIdle), 1);
        chk("rst_be",    int'(BlockEnable), 0);
        chk("rst_bx",    int'(BlockX), 0);
        chk("rst_ready", sy(ReadY), 0);
        repeat (2) tick();
        rst = 1'b0;

        // Bank 0 fill and issue
        write_mcu(3, 5, 384, 1'b0);
        chk("b0_done_idle", int'(DataInIdle), 1);
        chk("b0_done_be",   int'(BlockEnable), 0);
        tick();
        chk("b0_be", int'(BlockEnable), 1);
        chk("b0_bx", int'(BlockX), 3);
        chk("b0_by", int'(BlockY), 5);

        ReadIdle    = 1'b1;
        ReadAddress = 8'h9A;
        tick();
        chk("b0_rd_y",  sy(ReadY), 202);
        chk("b0_rd_cb", sy(ReadCb), 100);
        chk("b0_rd_cr", sy(ReadCr), -100);
        tick();
        chk("b0_be_drop", int'(BlockEnable), 0);
        ReadIdle = 1'b0;

        // Bank 1 fill with ReadBank held at 0: both banks full
        write_mcu(7, 9, 384, 1'b1);
        chk("both_full_idle", int'(DataInIdle), 0);
        chk("both_full_be",   int'(BlockEnable), 0);
        wr(0, 10, 77);
        wr(5, 63, 1);
        chk("blocked_idle", int'(DataInIdle), 0);
        ReadAddress = 8'h12;
        tick();
        chk("blocked_mem", sy(ReadY), 10);

        // Release bank 0 by moving to bank 1
        ReadBank    = 1'b1;
        ReadAddress = 8'h9A;
        tick();
        chk("rel_idle", int'(DataInIdle), 1);
        chk("rel_be",   int'(BlockEnable), 0);
        chk("b1_rd_y",  sy(ReadY), -203);
        tick();
        chk("b1_be",    int'(BlockEnable), 1);
        chk("b1_bx",    int'(BlockX), 7);
        chk("b1_by",    int'(BlockY), 9);
        chk("b1_rd_cb", sy(ReadCb), 50);
        chk("b1_rd_cr", sy(ReadCr), -50);

        // Blocks 6/7 must neither write nor complete
        wr(6, 10, 0);
        wr(7, 10, 0);
        wr(6, 63, 0);
        wr(7, 63, 0);
        chk("blk67_idle", int'(DataInIdle), 1);
        ReadBank    = 1'b0;
        ReadAddress = 8'h92;
        tick();
        chk("blk67_mem_b2", sy(ReadY), 138);
        ReadAddress = 8'h9A;
        tick();
        chk("blk67_mem_b3", sy(ReadY), 202);
        chk("b0_empty_be",  int'(BlockEnable), 0);

        // Asynchronous reset in the middle of an MCU
        write_mcu(11, 13, 200, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_be",   int'(BlockEnable), 0);
        chk("mid_rst_bx",   int'(BlockX), 0);
        chk("mid_rst_by",   int'(BlockY), 0);
        chk("mid_rst_y",    sy(ReadY), 0);
        chk("mid_rst_cb",   sy(ReadCb), 0);
        chk("mid_rst_cr",   sy(ReadCr), 0);
        chk("mid_rst_idle", int'(DataInIdle), 1);
        tick();
        rst = 1'b0;

        write_mcu(11, 13, 384, 1'b0);
        chk("post_rst_idle", int'(DataInIdle), 1);
        ReadAddress = 8'h35;
        tick();
        chk("post_rst_be", int'(BlockEnable), 1);
        chk("post_rst_bx", int'(BlockX), 11);
        chk("post_rst_by", int'(BlockY), 13);
        chk("post_rst_y",  sy(ReadY), 29);
        chk("post_rst_cb", sy(ReadCb), 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
